// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
package full_adder_pkg;

  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_MAX_WIDTH     = 64;

  typedef struct packed {
    logic [FA_MAX_WIDTH-1:0] sum;
    logic                    cout;
    logic                    ovf;
  } fa_result_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder used as a ripple-chain element.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  logic p;

  assign p       = a_i ^ b_i;
  assign sum_o   = p ^ c_i;
  assign carry_o = (a_i & b_i) | (c_i & p);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a single output register stage.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  fa_result_t       result_d;
  logic             unused_result;

  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             vld_q;

  // Operands are gated by in_valid so idle-cycle garbage never enters the chain.
  assign a        = in1 & {WIDTH{in_valid}};
  assign b        = in2 & {WIDTH{in_valid}};
  assign carry[0] = cin & in_valid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a_i     (a[i]),
      .b_i     (b[i]),
      .c_i     (carry[i]),
      .sum_o   (sum[i]),
      .carry_o (carry[i+1])
    );
  end

  always_comb begin
    result_d                 = '0;
    result_d.sum[WIDTH-1:0]  = sum;
    result_d.cout            = carry[WIDTH];
`ifdef FULL_ADDER_OVF_EN
    result_d.ovf             = carry[WIDTH] ^ carry[WIDTH-1];
`endif
  end

  // The package struct is sized for the widest legal adder; upper bits are idle.
  assign unused_result = ^result_d;

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        out_q  <= result_d.sum[WIDTH-1:0];
        cout_q <= result_d.cout;
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= result_d.ovf;
    end
  end

  assign ovf = ovf_q;
`endif

  assign out       = out_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH=1 and WIDTH=8 instances driven in lockstep.
module tb_full_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    res_t       e8;
    res_t       e1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       cin;

  logic [7:0] o8;
  logic       co8;
  logic       v8;
  logic [0:0] o1;
  logic       co1;
  logic       v1;
`ifdef FULL_ADDER_OVF_EN
  logic       ov8;
  logic       ov1;
`endif

  int   checks   = 0;
  int   failures = 0;
  logic chk_en   = 1'b0;
  res_t stg8;
  res_t stg1;
  res_t last8;
  res_t last1;
  res_t q8[$];
  res_t q1[$];
  vec_t vecs[14];

  always #5 clk = ~clk;

  full_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .out       (o8),
    .cout      (co8),
    .out_valid (v8)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf       (ov8)
`endif
  );

  full_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1[0:0]),
    .in2       (in2[0:0]),
    .cin       (cin),
    .out       (o1),
    .cout      (co1),
    .out_valid (v1)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf       (ov1)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] t;
    res_t r;
    t    = {1'b0, a} + {1'b0, b} + {8'b0, c};
    r.s  = t[7:0];
    r.co = t[8];
    r.ov = (a[7] == b[7]) && (t[7] != a[7]);
    return r;
  endfunction

  function automatic res_t model1(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [1:0] t;
    res_t r;
    t    = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, c};
    r.s  = {7'b0, t[0]};
    r.co = t[1];
    r.ov = (a[0] == b[0]) && (t[0] != a[0]);
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic c,
                              input logic [7:0] s8, input logic c8, input logic f8,
                              input logic s1, input logic c1, input logic f1);
    vec_t v;
    v.a  = a;
    v.b  = b;
    v.c  = c;
    v.e8 = '{s: s8, co: c8, ov: f8};
    v.e1 = '{s: {7'b0, s1}, co: c1, ov: f1};
    return v;
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input res_t e8, input res_t e1);
    in_valid = v;
    in1      = a;
    in2      = b;
    cin      = c;
    stg8     = e8;
    stg1     = e1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out8"}, 64'(o8), 64'd0);
    chk({tag, "_cout8"}, 64'(co8), 64'd0);
    chk({tag, "_vld8"}, 64'(v8), 64'd0);
    chk({tag, "_out1"}, 64'(o1), 64'd0);
    chk({tag, "_cout1"}, 64'(co1), 64'd0);
    chk({tag, "_vld1"}, 64'(v1), 64'd0);
`ifdef FULL_ADDER_OVF_EN
    chk({tag, "_ovf8"}, 64'(ov8), 64'd0);
    chk({tag, "_ovf1"}, 64'(ov1), 64'd0);
`endif
  endtask

  // Scoreboard capture: an accepted operand set produces one expected result.
  always @(posedge clk) begin
    if (rst_n && in_valid) begin
      q8.push_back(stg8);
      q1.push_back(stg1);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      q1.delete();
      last8 = '0;
      last1 = '0;
    end
    if (chk_en) begin
      chk("vld8", 64'(v8), 64'(q8.size() != 0));
      if (q8.size() != 0) last8 = q8.pop_front();
      chk("out8", 64'(o8), 64'(last8.s));
      chk("cout8", 64'(co8), 64'(last8.co));
      chk("vld1", 64'(v1), 64'(q1.size() != 0));
      if (q1.size() != 0) last1 = q1.pop_front();
      chk("out1", 64'(o1), 64'(last1.s[0]));
      chk("cout1", 64'(co1), 64'(last1.co));
`ifdef FULL_ADDER_OVF_EN
      chk("ovf8", 64'(ov8), 64'(last8.ov));
      chk("ovf1", 64'(ov1), 64'(last1.ov));
`endif
    end
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic       rv;

    vecs[0]  = mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[2]  = mk(8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(8'h00, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(8'h01, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[6]  = mk(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[7]  = mk(8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[8]  = mk(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[9]  = mk(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    vecs[10] = mk(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[12] = mk(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[13] = mk(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    rst_n    = 1'b1;
    in_valid = 1'b0;
    in1      = 8'h00;
    in2      = 8'h00;
    cin      = 1'b0;
    stg8     = '0;
    stg1     = '0;
    last8    = '0;
    last1    = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_zero("reset");
    chk_en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors, back to back
    for (int i = 0; i < 14; i++)
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e8, vecs[i].e1);

    // Single valid followed by idle cycles with changing operands
    drive(1'b1, 8'h3C, 8'h0F, 1'b1, model8(8'h3C, 8'h0F, 1'b1), model1(8'h3C, 8'h0F, 1'b1));
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      drive(1'b0, ra, rb, rc, '0, '0);
    end

    // Reset between the sampling edge and the next edge
    drive(1'b1, 8'h12, 8'h34, 1'b0, model8(8'h12, 8'h34, 1'b0), model1(8'h12, 8'h34, 1'b0));
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in1      = 8'hC3;
    in2      = 8'h5A;
    cin      = 1'b1;
    stg8     = model8(8'hC3, 8'h5A, 1'b1);
    stg1     = model1(8'hC3, 8'h5A, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic with random valid gaps
    for (int i = 0; i < 40; i++) begin
      rv = 1'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      drive(rv, ra, rb, rc, model8(ra, rb, rc), model1(ra, rb, rc));
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'h00, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
